alu_pipe_datapath: RTL and testbench
====================================

Name: alu_pipe_datapath

Overview:
- Parametrised, pipelined successor of the single-cycle register-file/ALU datapath.
- Contains a register file, an operand-select mux and an 8-op ALU in a 2-stage pipeline: operand latch, then execute/result register.
- Write-back occurs one edge after the result is registered.
- Full forwarding lets back-to-back dependent ops issue every cycle with no stalls.
- Sits between the decoder (control/immediate) and branch logic (EQ).

Parameters:
- DATA_WIDTH, 32, width of registers, operands and result.
- REG_FILE_ADDR_WIDTH, 5, register address width; register file has 2**REG_FILE_ADDR_WIDTH entries.
- A0_INDEX, 10, register index mirrored on the a0 output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  an op is issued this cycle.
- ALUsrc  in  1  0: op2 = RD2; 1: op2 = ImmOp.
- ALUctrl  in  3  operation select (see Behaviour).
- AD1  in  REG_FILE_ADDR_WIDTH  source register 1.
- AD2  in  REG_FILE_ADDR_WIDTH  source register 2.
- AD3  in  REG_FILE_ADDR_WIDTH  destination register.
- WE3  in  1  write result to AD3.
- ImmOp  in  DATA_WIDTH  immediate operand.
- out_valid  out  1  ALUout/EQ hold a completed op.
- ALUout  out  DATA_WIDTH  registered result.
- EQ  out  1  registered (op1 == op2) for that op.
- a0  out  DATA_WIDTH  architectural content of register A0_INDEX.

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers cleared to 0.
  - S1 and S2 valid bits cleared.
  - out_valid=0, ALUout=0, EQ=0, a0=0.
  - Any in-flight op is discarded and no write occurs.
  - Normal operation resumes on the first edge after rst returns to 1.
- Register x0 reads 0 and ignores writes.
- S1 (operand latch), on edge k with in_valid=1, captures:
  - op1 = fwd(AD1);
  - op2 = ALUsrc ? ImmOp : fwd(AD2);
  - ALUctrl, AD3, and we = WE3 & (AD3 != 0);
  - S1.valid = 1.
  - If in_valid=0, S1.valid=0 and the other fields are don't-care.
- S2 (execute), on edge k+1, captures:
  - ALUout = f(op1, op2, ALUctrl), EQ = (op1 == op2), out_valid = S1.valid;
  - AD3 and we, for write-back.
- Write-back: on edge k+2, if S2.valid & we, reg[AD3] = ALUout.
- Latency: issue at edge k → out_valid=1 in the cycle after edge k+1 → register visible (and a0 updated) after edge k+2. Throughput is 1 op/cycle.
- Forwarding, fwd(r), priority order:
  1. r == 0 → 0.
  2. S1.valid & S1.we & S1.AD3 == r → combinational ALU result of S1.
  3. S2.valid & S2.we & S2.AD3 == r → S2 ALUout.
  4. otherwise reg[r].
- ALUctrl ops (wrap-around modulo 2**DATA_WIDTH; no overflow flag):
  - 000 add; 001 sub; 010 and; 011 or; 100 xor;
  - 101 sll, shift by op2[log2(DATA_WIDTH)-1:0];
  - 110 srl (logical), same shift amount;
  - 111 slt, signed, result 1 or 0 zero-extended.
- When out_valid=0, ALUout and EQ hold their last values.
- a0 is driven from the register array only; it is not forwarded.

Test Plan:
- Reset mid-operation: issue addi x10=x0+5, then assert rst before edge k+2 → x10 stays 0, a0=0, out_valid=0; after release, reading x10 returns 0.
- Basic ops: x1=7 and x2=3 (via addi); issue each ALUctrl 000..111 with AD1=x1, AD2=x2 → ALUout = 10, 4, 3, 7, 4, 56, 0, 0 respectively, 2 cycles after issue, with out_valid=1.
- Back-to-back forwarding: addi x1=x0+1, then add x1=x1+x1, then add x1=x1+x1 on consecutive cycles → results 1, 2, 4; final x1=4.
- S2 forwarding with a bubble: addi x3=x0+9, then an idle cycle, then sub x4=x3-x3 → ALUout=0 and EQ=1.
- x0 protection and wrap: addi x0=x0+5 then add x5=x0+x0 → 0. ImmOp=0xFFFFFFFF added to x6=1 → ALUout=0, EQ=0.
- a0 tracking: addi x10=x0+42 → a0=42 exactly one cycle after out_valid; WE3=0 ops to x10 leave a0 unchanged.

Source files
------------

// File: rtl/alu_pipe_datapath.sv
// Pipelined register-file / ALU datapath.
// Stage S1 latches forwarded operands, stage S2 registers the ALU result.
// Write-back to the register file happens one edge after the result is registered.
// Full forwarding from S1 (combinational ALU result) and S2 (registered result)
// lets dependent ops issue on consecutive cycles with no stalls.
module alu_pipe_datapath #(
  parameter int DATA_WIDTH          = 32,
  parameter int REG_FILE_ADDR_WIDTH = 5,
  parameter int A0_INDEX            = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic                           ALUsrc,
  input  logic [2:0]                     ALUctrl,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] AD1,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] AD2,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] AD3,
  input  logic                           WE3,
  input  logic [DATA_WIDTH-1:0]          ImmOp,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          ALUout,
  output logic                           EQ,
  output logic [DATA_WIDTH-1:0]          a0
);

  localparam int DW    = DATA_WIDTH;
  localparam int AW    = REG_FILE_ADDR_WIDTH;
  localparam int NREGS = 1 << AW;
  localparam int SHW   = $clog2(DATA_WIDTH);
  localparam logic [AW-1:0] A0_ADDR = AW'(A0_INDEX);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  // Architectural register file.
  logic [DW-1:0] regs [NREGS];

  // S1: operand latch.
  logic          s1_valid;
  logic [DW-1:0] s1_op1;
  logic [DW-1:0] s1_op2;
  alu_op_e       s1_ctrl;
  logic [AW-1:0] s1_ad3;
  logic          s1_we;

  // S2: result register plus write-back destination.
  logic          s2_we;
  logic [AW-1:0] s2_ad3;

  // Combinational ALU outputs for the op held in S1.
  logic [DW-1:0] alu_res;
  logic          alu_eq;

  // Forwarded operands for the op being issued this cycle.
  logic [DW-1:0] fwd1;
  logic [DW-1:0] fwd2;

  // ALU evaluation of the S1 op.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    alu_res = '0;
    alu_eq  = (s1_op1 == s1_op2);
    unique case (s1_ctrl)
      OP_ADD: alu_res = s1_op1 + s1_op2;
      OP_SUB: alu_res = s1_op1 - s1_op2;
      OP_AND: alu_res = s1_op1 & s1_op2;
      OP_OR:  alu_res = s1_op1 | s1_op2;
      OP_XOR: alu_res = s1_op1 ^ s1_op2;
      OP_SLL: alu_res = s1_op1 << s1_op2[SHW-1:0];
      OP_SRL: alu_res = s1_op1 >> s1_op2[SHW-1:0];
      OP_SLT: alu_res = {{(DW-1){1'b0}}, ($signed(s1_op1) < $signed(s1_op2))};
      default: alu_res = '0;
    endcase
  end

  // Source 1 forwarding: x0, then youngest in-flight producer, then register file.
  always_comb begin
    fwd1 = regs[AD1];
    if (AD1 == '0)
      fwd1 = '0;
    else if (s1_valid && s1_we && (s1_ad3 == AD1))
      fwd1 = alu_res;
    else if (out_valid && s2_we && (s2_ad3 == AD1))
      fwd1 = ALUout;
  end

  // Source 2 forwarding, same priority as source 1.
  always_comb begin
    fwd2 = regs[AD2];
    if (AD2 == '0)
      fwd2 = '0;
    else if (s1_valid && s1_we && (s1_ad3 == AD2))
      fwd2 = alu_res;
    else if (out_valid && s2_we && (s2_ad3 == AD2))
      fwd2 = ALUout;
  end

  // S1 operand latch; a write to x0 is turned into no write here.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_op1   <= '0;
      s1_op2   <= '0;
      s1_ctrl  <= OP_ADD;
      s1_ad3   <= '0;
      s1_we    <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op1  <= fwd1;
        s1_op2  <= ALUsrc ? ImmOp : fwd2;
        s1_ctrl <= alu_op_e'(ALUctrl);
        s1_ad3  <= AD3;
        s1_we   <= WE3 && (AD3 != '0);
      end
    end
  end

  // S2 result register; result and EQ hold when no op completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      ALUout    <= '0;
      EQ        <= 1'b0;
      s2_ad3    <= '0;
      s2_we     <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        ALUout <= alu_res;
        EQ     <= alu_eq;
        s2_ad3 <= s1_ad3;
        s2_we  <= s1_we;
      end
    end
  end

  // Register file write-back from S2.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the register file is architecturally cleared on reset, so this
    // array is built from resettable flops rather than a RAM macro.
    if (!rst) begin
      regs <= '{default: '0};
    end else if (out_valid && s2_we) begin
      regs[s2_ad3] <= ALUout;
    end
  end

  // a0 mirrors committed state only, never forwarded values.
  assign a0 = regs[A0_ADDR];

endmodule

// File: tb/tb_alu_pipe_datapath.sv
// Self-checking bench for alu_pipe_datapath: expected results are queued at
// issue time and compared, with latency, when out_valid rises.
module tb_alu_pipe_datapath;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        ALUsrc;
  logic [2:0]  ALUctrl;
  logic [4:0]  AD1;
  logic [4:0]  AD2;
  logic [4:0]  AD3;
  logic        WE3;
  logic [31:0] ImmOp;
  logic        out_valid;
  logic [31:0] ALUout;
  logic        EQ;
  logic [31:0] a0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    logic        eq;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  alu_pipe_datapath #(
    .DATA_WIDTH(32),
    .REG_FILE_ADDR_WIDTH(5),
    .A0_INDEX(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .ALUsrc(ALUsrc),
    .ALUctrl(ALUctrl),
    .AD1(AD1),
    .AD2(AD2),
    .AD3(AD3),
    .WE3(WE3),
    .ImmOp(ImmOp),
    .out_valid(out_valid),
    .ALUout(ALUout),
    .EQ(EQ),
    .a0(a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every completed op must match the oldest queued entry
  // and appear exactly two edges after issue.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out_valid: got ALUout=%h EQ=%b, want no completion", ALUout, EQ);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (ALUout !== e.res || EQ !== e.eq) begin
          bad++;
          $display("FAIL result: got ALUout=%h EQ=%b, want ALUout=%h EQ=%b", ALUout, EQ, e.res, e.eq);
        end
        total++;
        if (cyc - e.cyc !== 2) begin
          bad++;
          $display("FAIL latency: got %0d edges, want 2", cyc - e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one op for one cycle and queue its expected result.
  task automatic issue(input logic [2:0] ctrl, input logic src,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                       input logic we, input logic [31:0] imm,
                       input logic [31:0] er, input logic ee);
    exp_t e;
    in_valid = 1'b1;
    ALUctrl  = ctrl;
    ALUsrc   = src;
    AD1      = a1;
    AD2      = a2;
    AD3      = a3;
    WE3      = we;
    ImmOp    = imm;
    e.res = er;
    e.eq  = ee;
    e.cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    WE3      = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Wait (bounded) until every queued op has completed, then let write-back settle.
  task automatic drain(input string name);
    int n;
    in_valid = 1'b0;
    WE3      = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d ops outstanding, want 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(2);
    total++;
    if (out_valid !== 1'b0 || ALUout !== 32'h0 || EQ !== 1'b0 || a0 !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: got out_valid=%b ALUout=%h EQ=%b a0=%h, want all 0",
               out_valid, ALUout, EQ, a0);
    end
    rst = 1'b1;
    idle(1);
    // addi x10 = x0 + 5, then reset lands before write-back.
    in_valid = 1'b1; ALUctrl = 3'b000; ALUsrc = 1'b1;
    AD1 = 5'd0; AD2 = 5'd0; AD3 = 5'd10; WE3 = 1'b1; ImmOp = 32'd5;
    @(posedge clk);
    #2 in_valid = 1'b0; WE3 = 1'b0;
    #1 rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || ALUout !== 32'h0 || a0 !== 32'h0) begin
      bad++;
      $display("FAIL reset_midop: got out_valid=%b ALUout=%h a0=%h, want 0 0 0", out_valid, ALUout, a0);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (a0 !== 32'h0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: got a0=%h out_valid=%b, want 0 0", a0, out_valid);
    end
    rst = 1'b1;
    idle(3);
    total++;
    if (a0 !== 32'h0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got a0=%h out_valid=%b, want 0 0", a0, out_valid);
    end
    // Read x10 back: x10 + x0 must be 0.
    issue(3'b000, 1'b0, 5'd10, 5'd0, 5'd0, 1'b0, 32'h0, 32'd0, 1'b1);
    drain("reset_read");
  endtask

  task automatic test_basic_ops();
    logic [31:0] want [8];
    want = '{32'd10, 32'd4, 32'd3, 32'd7, 32'd4, 32'd56, 32'd0, 32'd0};
    issue(3'b000, 1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 32'd7, 32'd7, 1'b0);
    issue(3'b000, 1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 32'd3, 32'd3, 1'b0);
    for (int i = 0; i < 8; i++)
      issue(3'(i), 1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 32'h0, want[i], 1'b0);
    drain("basic_ops");
  endtask

  task automatic test_back_to_back();
    issue(3'b000, 1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 32'd1, 32'd1, 1'b0);
    issue(3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 1'b1, 32'h0, 32'd2, 1'b1);
    issue(3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 1'b1, 32'h0, 32'd4, 1'b1);
    drain("b2b");
    issue(3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0, 32'h0, 32'd4, 1'b0);
    drain("b2b_read");
    idle(2);
    total++;
    if (out_valid !== 1'b0 || ALUout !== 32'd4 || EQ !== 1'b0) begin
      bad++;
      $display("FAIL hold_when_idle: got out_valid=%b ALUout=%h EQ=%b, want 0 4 0", out_valid, ALUout, EQ);
    end
  endtask

  task automatic test_s2_forward();
    issue(3'b000, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 32'd9, 32'd9, 1'b0);
    idle(1);
    issue(3'b001, 1'b0, 5'd3, 5'd3, 5'd4, 1'b1, 32'h0, 32'd0, 1'b1);
    drain("s2_fwd");
    // x3 committed: x3 + 1 must be 10.
    issue(3'b000, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 32'd1, 32'd10, 1'b0);
    drain("s2_commit");
  endtask

  task automatic test_x0_and_wrap();
    issue(3'b000, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 32'd5, 32'd5, 1'b0);
    issue(3'b000, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 32'h0, 32'd0, 1'b1);
    issue(3'b000, 1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 32'd1, 32'd1, 1'b0);
    issue(3'b000, 1'b1, 5'd6, 5'd0, 5'd7, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    // Signed compare: -1 < 1.
    issue(3'b111, 1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(3'b111, 1'b0, 5'd0, 5'd6, 5'd0, 1'b0, 32'h0, 32'd1, 1'b0);
    drain("x0_wrap");
  endtask

  task automatic test_a0_tracking();
    issue(3'b000, 1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 32'd42, 32'd42, 1'b0);
    in_valid = 1'b0;
    WE3 = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || a0 !== 32'd0) begin
      bad++;
      $display("FAIL a0_before_wb: got out_valid=%b a0=%h, want 1 0", out_valid, a0);
    end
    @(negedge clk);
    total++;
    if (a0 !== 32'd42) begin
      bad++;
      $display("FAIL a0_after_wb: got a0=%h, want 2a", a0);
    end
    issue(3'b000, 1'b1, 5'd0, 5'd0, 5'd10, 1'b0, 32'd7, 32'd7, 1'b0);
    drain("a0_nowrite");
    idle(2);
    total++;
    if (a0 !== 32'd42) begin
      bad++;
      $display("FAIL a0_we3_zero: got a0=%h, want 2a", a0);
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; ALUsrc = 1'b0; ALUctrl = 3'b000;
    AD1 = '0; AD2 = '0; AD3 = '0; WE3 = 1'b0; ImmOp = '0;
    test_reset();
    test_basic_ops();
    test_back_to_back();
    test_s2_forward();
    test_x0_and_wrap();
    test_a0_tracking();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
